// File: rtl/adder_sequencer_if.sv
// Handshake bundle for adder_sequencer: start channel, operand-in channel, result-out channel, busy status.
interface adder_sequencer_if;
    logic        io_start_valid;
    logic        io_start_ready;
    logic        io_start_carry;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [15:0] io_in_a;
    logic [15:0] io_in_b;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [15:0] io_out_sum;
    logic        io_out_last;
    logic        io_out_carry;
    logic        io_out_overflow;
    logic        io_busy;

    modport slave (
        input  io_start_valid,
        output io_start_ready,
        input  io_start_carry,
        input  io_in_valid,
        output io_in_ready,
        input  io_in_a,
        input  io_in_b,
        output io_out_valid,
        input  io_out_ready,
        output io_out_sum,
        output io_out_last,
        output io_out_carry,
        output io_out_overflow,
        output io_busy
    );

    modport master (
        output io_start_valid,
        input  io_start_ready,
        output io_start_carry,
        output io_in_valid,
        input  io_in_ready,
        output io_in_a,
        output io_in_b,
        input  io_out_valid,
        output io_out_ready,
        input  io_out_sum,
        input  io_out_last,
        input  io_out_carry,
        input  io_out_overflow,
        input  io_busy
    );
endinterface

// File: rtl/adder_sequencer.sv
// Word-serial multi-word adder: NUM_WORDS 16-bit words, LSW first, one result word per cycle.
// Optional signed-overflow flag on the last word is enabled by defining ADDER_SEQUENCER_OVERFLOW_EN.
module adder_sequencer #(
    parameter int unsigned NUM_WORDS = 4
) (
    input logic              clock,
    input logic              reset,
    adder_sequencer_if.slave bus
);
    localparam logic [0:0]  IDLE     = 1'b0;
    localparam logic [0:0]  RUN      = 1'b1;
    localparam int unsigned CW       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);

    logic [0:0]    state;
    logic [CW-1:0] count;
    logic          carry;

    logic          out_valid;
    logic [15:0]   out_sum;
    logic          out_last;
    logic          out_carry;

    logic          in_ready;
    logic          start_fire;
    logic          in_fire;
    logic          is_last;
    logic [16:0]   result;

    always_comb begin
        in_ready   = (state == RUN) && (!out_valid || bus.io_out_ready);
        start_fire = bus.io_start_valid && (state == IDLE);
        in_fire    = bus.io_in_valid && in_ready;
        is_last    = (count == LAST_IDX);
        result     = {1'b0, bus.io_in_a} + {1'b0, bus.io_in_b} + {16'b0, carry};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_fire) begin
                        state <= RUN;
                        count <= '0;
                        carry <= bus.io_start_carry;
                    end
                end
                RUN: begin
                    if (in_fire) begin
                        carry <= result[16];
                        if (is_last) begin
                            state <= IDLE;
                            count <= '0;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A new word may overwrite the register in the same cycle the old one is consumed.
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            out_carry <= 1'b0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            out_sum   <= result[15:0];
            out_last  <= is_last;
            out_carry <= is_last && result[16];
        end else if (bus.io_out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ADDER_SEQUENCER_OVERFLOW_EN
    logic out_overflow;

    always_ff @(posedge clock) begin
        if (!reset) begin
            out_overflow <= 1'b0;
        end else if (in_fire) begin
            out_overflow <= is_last && (bus.io_in_a[15] == bus.io_in_b[15])
                                    && (result[15] != bus.io_in_a[15]);
        end
    end

    assign bus.io_out_overflow = out_overflow;
`else
    assign bus.io_out_overflow = 1'b0;
`endif

    assign bus.io_start_ready = (state == IDLE);
    assign bus.io_in_ready    = in_ready;
    assign bus.io_busy        = (state == RUN);
    assign bus.io_out_valid   = out_valid;
    assign bus.io_out_sum     = out_sum;
    assign bus.io_out_last    = out_last;
    assign bus.io_out_carry   = out_carry;
endmodule
